// File: rtl/motor_pkg.sv
// motor_pkg: encodings shared by motor_sequencer, the Motor driver and the
// house-level request logic.
//   state_t  : sequencer FSM states
//   req_t    : effective request out of the arbiter
//   CMD_*    : 2-bit Motor command encodings (11 is never used)
//   DIR_*    : direction encoding of auto_dir and of the latched reversal target
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_DEAD,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_STOP,
        REQ_UP,
        REQ_DOWN
    } req_t;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/motor_sequencer_if.sv
// motor_sequencer_if: request/status bundle between house logic and the
// sequencer.
//   master : house side - drives requests, limit flags and fault_clr
//   slave  : sequencer side - drives cmd, status flags and auto_ready
interface motor_sequencer_if;
    logic       man_up;
    logic       man_down;
    logic       man_stop;
    logic       auto_valid;
    logic       auto_dir;
    logic       auto_ready;
    logic       tope_a_s;
    logic       tope_b_s;
    logic       fault_clr;
    logic [1:0] cmd;
    logic       busy;
    logic       at_top;
    logic       at_bottom;
    logic       fault;

    modport master (
        output man_up, man_down, man_stop, auto_valid, auto_dir,
        output tope_a_s, tope_b_s, fault_clr,
        input  auto_ready, cmd, busy, at_top, at_bottom, fault
    );

    modport slave (
        input  man_up, man_down, man_stop, auto_valid, auto_dir,
        input  tope_a_s, tope_b_s, fault_clr,
        output auto_ready, cmd, busy, at_top, at_bottom, fault
    );
endinterface

// File: rtl/motor_req_arb.sv
// motor_req_arb: combinational priority arbiter.
//   in  : man_up, man_down, man_stop, auto_valid, auto_dir,
//         idle (sequencer idle and out of reset), fault
//   out : req (effective request), auto_ready
// Priority: man_stop, then manual direction (both together = stop), then an
// auto request that is handshaken this cycle.
module motor_req_arb
    import motor_pkg::*;
(
    input  logic man_up,
    input  logic man_down,
    input  logic man_stop,
    input  logic auto_valid,
    input  logic auto_dir,
    input  logic idle,
    input  logic fault,
    output req_t req,
    output logic auto_ready
);

    always_comb begin
        auto_ready = idle & ~(man_up | man_down | man_stop) & ~fault;
        req        = REQ_NONE;
        if (man_stop || (man_up && man_down))
            req = REQ_STOP;
        else if (man_up)
            req = REQ_UP;
        else if (man_down)
            req = REQ_DOWN;
        else if (auto_valid && auto_ready)
            req = (auto_dir == DIR_UP) ? REQ_UP : REQ_DOWN;
    end

endmodule

// File: rtl/motor_sequencer.sv
// motor_sequencer: drives the Motor cmd from manual/auto requests, stops on
// the driver's limit flags and inserts a stopped dead time before reversals.
//   clk, reset (async, active low)
//   bus (slave): requests, limit flags, fault_clr in; cmd, busy, at_top,
//                at_bottom, fault, auto_ready out
// Optional: define MOTOR_SEQ_TIMEOUT_EN to add the travel timeout that latches
// FAULT until fault_clr. Without it fault stays 0 and fault_clr is ignored.
module motor_sequencer
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 24
) (
    input  logic               clk,
    input  logic               reset,
    motor_sequencer_if.slave   bus
);

`ifdef MOTOR_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pend_q, pend_d;
    logic             top_q, top_d, bot_q, bot_d;
    logic [1:0]       cmd_q;
    logic             busy_q, fault_q;
    logic             moving_up, hit_limit, pend_limit;
    req_t             req;

    // idle is gated with reset so auto_ready reads 0 while reset is held
    motor_req_arb u_arb (
        .man_up     (bus.man_up),
        .man_down   (bus.man_down),
        .man_stop   (bus.man_stop),
        .auto_valid (bus.auto_valid),
        .auto_dir   (bus.auto_dir),
        .idle       ((state_q == ST_IDLE) && reset),
        .fault      (fault_q),
        .req        (req),
        .auto_ready (bus.auto_ready)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        top_d      = top_q;
        bot_d      = bot_q;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);  // saturate, never wrap
        moving_up  = (state_q == ST_UP);
        hit_limit  = moving_up ? bus.tope_a_s : bus.tope_b_s;
        pend_limit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((req == REQ_UP && !bus.tope_a_s) || (req == REQ_DOWN && !bus.tope_b_s)) begin
                    state_d = (req == REQ_UP) ? ST_UP : ST_DOWN;
                    cnt_d   = '0;
                    top_d   = 1'b0;
                    bot_d   = 1'b0;
                end
            end
            ST_UP, ST_DOWN: begin
                // limit wins over everything so cmd drops on the same edge
                if (hit_limit) begin
                    state_d = ST_IDLE;
                    top_d   = moving_up;
                    bot_d   = ~moving_up;
                end else if (TIMEOUT_EN && cnt_q == TO_LAST) begin
                    state_d = ST_FAULT;
                end else if (req == REQ_STOP) begin
                    state_d = ST_IDLE;
                end else if (req == (moving_up ? REQ_DOWN : REQ_UP)) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                    pend_d  = moving_up ? DIR_DOWN : DIR_UP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DEAD: begin
                if (req == REQ_STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    // a newer direction request retargets without restarting the count
                    if (req == REQ_UP)
                        pend_d = DIR_UP;
                    else if (req == REQ_DOWN)
                        pend_d = DIR_DOWN;
                    pend_limit = (pend_d == DIR_UP) ? bus.tope_a_s : bus.tope_b_s;
                    if (cnt_q == DEAD_LAST) begin
                        if (pend_limit) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = (pend_d == DIR_UP) ? ST_UP : ST_DOWN;
                            cnt_d   = '0;
                            top_d   = 1'b0;
                            bot_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are registered from the next state so they change on the
    // same edge that samples the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= DIR_DOWN;
            top_q   <= 1'b0;
            bot_q   <= 1'b0;
            cmd_q   <= CMD_STOP;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            cmd_q   <= (state_d == ST_UP)   ? CMD_UP   :
                       (state_d == ST_DOWN) ? CMD_DOWN : CMD_STOP;
            busy_q  <= (state_d != ST_IDLE);
            fault_q <= TIMEOUT_EN && (state_d == ST_FAULT);
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.busy      = busy_q;
    assign bus.at_top    = top_q;
    assign bus.at_bottom = bot_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// tb_motor_sequencer: directed scenarios plus randomized traffic checked
// against a behavioural model of the sequencer (DEAD_CYCLES=4,
// TIMEOUT_CYCLES=20). Honours MOTOR_SEQ_TIMEOUT_EN like the design.
module tb_motor_sequencer;

    localparam int DEAD = 4;
    localparam int TMO  = 20;
`ifdef MOTOR_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    motor_sequencer_if bus();

    motor_sequencer #(.DEAD_CYCLES(DEAD), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_dir: +1 travelling up, -1 down, 0 stopped; m_dead: cycles of dead time left
    int m_dir, m_dead, m_pend, m_travel, m_r;
    bit m_fault, m_top, m_bot;

    function automatic bit lim(int d);
        return (d == 1) ? bus.tope_a_s : bus.tope_b_s;
    endfunction

    function automatic bit m_idle();
        return (m_dir == 0) && (m_dead == 0) && !m_fault;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir = 0; m_dead = 0; m_pend = 0; m_travel = 0;
            m_fault = 0; m_top = 0; m_bot = 0;
        end else begin
            // request: 2 = stop, +1 up, -1 down, 0 none
            if (bus.man_stop || (bus.man_up && bus.man_down)) m_r = 2;
            else if (bus.man_up) m_r = 1;
            else if (bus.man_down) m_r = -1;
            else if (bus.auto_valid && m_idle()) m_r = bus.auto_dir ? 1 : -1;
            else m_r = 0;

            if (m_fault) begin
                if (bus.fault_clr) m_fault = 0;
            end else if (m_dead > 0) begin
                if (m_r == 2) m_dead = 0;
                else begin
                    if (m_r == 1 || m_r == -1) m_pend = m_r;
                    m_dead--;
                    if (m_dead == 0 && !lim(m_pend)) begin
                        m_dir = m_pend; m_travel = 0; m_top = 0; m_bot = 0;
                    end
                end
            end else if (m_dir != 0) begin
                if (lim(m_dir)) begin
                    m_top = (m_dir == 1); m_bot = (m_dir == -1); m_dir = 0;
                end else if (TO_EN && m_travel + 1 == TMO) begin
                    m_dir = 0; m_fault = 1;
                end else if (m_r == 2) m_dir = 0;
                else if (m_r == -m_dir) begin
                    m_pend = m_r; m_dir = 0; m_dead = DEAD;
                end else m_travel++;
            end else if ((m_r == 1 || m_r == -1) && !lim(m_r)) begin
                m_dir = m_r; m_travel = 0; m_top = 0; m_bot = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic quiet();
        bus.man_up = 0; bus.man_down = 0; bus.man_stop = 0;
        bus.auto_valid = 0; bus.auto_dir = 0;
        bus.tope_a_s = 0; bus.tope_b_s = 0; bus.fault_clr = 0;
    endtask

    // inputs are set at a falling edge; step returns at the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        bus.man_stop = 1; step(); bus.man_stop = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        quiet();
        rst_n = 0;
        step(); step();
        checks++;
        if (bus.cmd !== 2'b00 || bus.busy !== 1'b0 || bus.at_top !== 1'b0 ||
            bus.at_bottom !== 1'b0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cmd=%b busy=%b top=%b bot=%b fault=%b want all 0",
                     bus.cmd, bus.busy, bus.at_top, bus.at_bottom, bus.fault);
        end
        #1;
        checks++;
        if (bus.auto_ready !== 1'b0) begin
            errors++; $display("FAIL reset_auto_ready got %b want 0", bus.auto_ready);
        end
        rst_n = 1;
        #1;
        checks++;
        if (bus.auto_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_auto_ready got %b want 1", bus.auto_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_up_limit();
        bus.man_up = 1; step(); bus.man_up = 0;
        checks++;
        if (bus.cmd !== 2'b01 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL up_start cmd=%b busy=%b want 01/1", bus.cmd, bus.busy);
        end
        bus.tope_a_s = 1; step();
        checks++;
        if (bus.cmd !== 2'b00 || bus.at_top !== 1'b1 || bus.busy !== 1'b0 || bus.at_bottom !== 1'b0) begin
            errors++;
            $display("FAIL top_limit cmd=%b top=%b busy=%b bot=%b want 00/1/0/0",
                     bus.cmd, bus.at_top, bus.busy, bus.at_bottom);
        end
        bus.tope_a_s = 0;
    endtask

    task automatic test_reversal();
        int n;
        bus.man_up = 1; step(); bus.man_up = 0;
        bus.man_down = 1; step(); bus.man_down = 0;
        n = 0;
        for (int i = 0; i < 12 && bus.cmd === 2'b00; i++) begin
            n++; step();
        end
        checks++;
        if (n != DEAD || bus.cmd !== 2'b10) begin
            errors++; $display("FAIL dead_time stop_cycles=%0d cmd=%b want %0d then 10", n, bus.cmd, DEAD);
        end
        checks++;
        if (bus.at_top !== 1'b0) begin
            errors++; $display("FAIL flag_clear at_top=%b want 0", bus.at_top);
        end
        // reverse again, then abort the dead time
        bus.man_up = 1; step(); bus.man_up = 0;
        step();
        bus.man_stop = 1; step(); bus.man_stop = 0;
        checks++;
        if (bus.cmd !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL dead_abort cmd=%b busy=%b want 00/0", bus.cmd, bus.busy);
        end
        repeat (DEAD + 2) step();
        checks++;
        if (bus.cmd !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL dead_discard cmd=%b busy=%b want 00/0", bus.cmd, bus.busy);
        end
    endtask

    task automatic test_arbitration();
        bus.auto_valid = 1; bus.auto_dir = 0; bus.man_up = 1;
        #1;
        checks++;
        if (bus.auto_ready !== 1'b0) begin
            errors++; $display("FAIL arb_ready_manual got %b want 0", bus.auto_ready);
        end
        step(); bus.man_up = 0;
        checks++;
        if (bus.cmd !== 2'b01) begin
            errors++; $display("FAIL arb_manual_wins cmd=%b want 01", bus.cmd);
        end
        bus.man_stop = 1; step(); bus.man_stop = 0;
        #1;
        checks++;
        if (bus.cmd !== 2'b00 || bus.auto_ready !== 1'b1) begin
            errors++; $display("FAIL arb_after_stop cmd=%b ready=%b want 00/1", bus.cmd, bus.auto_ready);
        end
        step(); bus.auto_valid = 0;
        checks++;
        if (bus.cmd !== 2'b10) begin
            errors++; $display("FAIL arb_auto_accept cmd=%b want 10", bus.cmd);
        end
        go_idle();
    endtask

    task automatic test_limit_drop();
        bus.tope_b_s = 1; bus.auto_valid = 1; bus.auto_dir = 0;
        #1;
        checks++;
        if (bus.auto_ready !== 1'b1) begin
            errors++; $display("FAIL drop_handshake ready=%b want 1", bus.auto_ready);
        end
        step(); bus.auto_valid = 0;
        checks++;
        if (bus.cmd !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL drop_stays_idle cmd=%b busy=%b want 00/0", bus.cmd, bus.busy);
        end
        bus.tope_b_s = 0;
    endtask

    task automatic test_timeout();
        int n;
        bus.man_up = 1; step(); bus.man_up = 0;
        n = 0;
        for (int i = 0; i < 40 && bus.cmd === 2'b01; i++) begin
            n++; step();
        end
        if (TO_EN) begin
            checks++;
            if (n != TMO || bus.fault !== 1'b1 || bus.cmd !== 2'b00) begin
                errors++;
                $display("FAIL timeout up_cycles=%0d fault=%b cmd=%b want %0d/1/00", n, bus.fault, bus.cmd, TMO);
            end
            bus.man_up = 1; step(); bus.man_up = 0;
            bus.man_stop = 1; step(); bus.man_stop = 0;
            checks++;
            if (bus.cmd !== 2'b00 || bus.fault !== 1'b1) begin
                errors++; $display("FAIL fault_holds cmd=%b fault=%b want 00/1", bus.cmd, bus.fault);
            end
            bus.fault_clr = 1; step(); bus.fault_clr = 0;
            checks++;
            if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL fault_clr fault=%b busy=%b want 0/0", bus.fault, bus.busy);
            end
        end else begin
            checks++;
            if (n != 40 || bus.fault !== 1'b0) begin
                errors++; $display("FAIL no_timeout up_cycles=%0d fault=%b want 40/0", n, bus.fault);
            end
            go_idle();
        end
    endtask

    task automatic test_reset_mid();
        bus.man_down = 1; step(); bus.man_down = 0;
        checks++;
        if (bus.cmd !== 2'b10) begin
            errors++; $display("FAIL mid_down_start cmd=%b want 10", bus.cmd);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (bus.cmd !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL async_reset cmd=%b busy=%b want 00/0", bus.cmd, bus.busy);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_random();
        int dens;
        bit  ar;
        quiet();
        rst_n = 0; step(); rst_n = 1;
        for (int c = 0; c < 1500; c++) begin
            // alternate busy and calm phases so long travels (timeouts) happen
            dens = ((c / 150) % 2 == 0) ? 8 : 1;
            bus.man_stop   = ($urandom_range(99) < 4 * dens / 8 + 0);
            bus.man_up     = ($urandom_range(99) < dens);
            bus.man_down   = ($urandom_range(99) < dens);
            bus.auto_valid = ($urandom_range(99) < 30);
            bus.auto_dir   = $urandom_range(1);
            bus.tope_a_s   = ($urandom_range(99) < dens * 3 / 4);
            bus.tope_b_s   = ($urandom_range(99) < dens * 3 / 4);
            bus.fault_clr  = ($urandom_range(99) < 10);
            #1;
            ar = m_idle() && !(bus.man_up || bus.man_down || bus.man_stop);
            checks++;
            if (bus.auto_ready !== ar) begin
                errors++; $display("FAIL rnd_auto_ready c=%0d got %b want %b", c, bus.auto_ready, ar);
            end
            step();
            checks++;
            if (bus.cmd !== ((m_dir == 1) ? 2'b01 : (m_dir == -1) ? 2'b10 : 2'b00) ||
                bus.busy !== !m_idle() || bus.at_top !== m_top ||
                bus.at_bottom !== m_bot || bus.fault !== m_fault) begin
                errors++;
                $display("FAIL rnd_outputs c=%0d cmd=%b busy=%b top=%b bot=%b fault=%b want dir=%0d busy=%b top=%b bot=%b fault=%b",
                         c, bus.cmd, bus.busy, bus.at_top, bus.at_bottom, bus.fault,
                         m_dir, !m_idle(), m_top, m_bot, m_fault);
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_up_limit();
        test_reversal();
        test_arbitration();
        test_limit_drop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Controller placed between the house-level request logic and the `Motor` driver block. It arbitrates between manual push-button requests and automatic (sensor/schedule) requests, and issues the 2-bit `cmd` to `Motor`. It uses the driver's registered limit flags to stop travel. It also enforces a stopped dead time before any direction reversal and, optionally, a travel timeout that latches a fault.

## Interface
- `DEAD_CYCLES`, default 1000: cycles `cmd` is held at 00 between opposite-direction moves (≥1).
- `TIMEOUT_CYCLES`, default 100000: maximum cycles of continuous travel before fault (≥2).
- `CNT_W`, default 24: counter width; must satisfy 2^CNT_W > max(`DEAD_CYCLES`, `TIMEOUT_CYCLES`).

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `man_up` in 1: manual up request, level.
- `man_down` in 1: manual down request, level.
- `man_stop` in 1: manual stop, level, highest priority.
- `auto_valid` in 1: automatic request valid.
- `auto_dir` in 1: automatic direction, 1 = up, 0 = down.
- `auto_ready` out 1: automatic request accepted when `auto_valid` && `auto_ready`.
- `tope_a_s` in 1: top limit reached (from `Motor` `TopeA_S`).
- `tope_b_s` in 1: bottom limit reached (from `Motor` `TopeB_S`).
- `fault_clr` in 1: clears FAULT state.
- `cmd` out 2: to `Motor`; 01 = up, 10 = down, 00 = stop. 11 is never driven.
- `busy` out 1: state ≠ IDLE.
- `at_top` out 1: last move ended on the top limit.
- `at_bottom` out 1: last move ended on the bottom limit.
- `fault` out 1: timeout fault latched.

## Operation
- States: IDLE, UP, DOWN, DEAD, FAULT. `cmd` = 01 only in UP, 10 only in DOWN, 00 otherwise.
- Effective request, evaluated each cycle in priority order:
  1. `man_stop`.
  2. Manual direction. `man_up` && `man_down` together counts as stop.
  3. Accepted auto request.
- IDLE:
  - Up request with `tope_a_s`=0 → UP. Down request with `tope_b_s`=0 → DOWN.
  - A request toward an asserted limit is dropped; state stays IDLE. An auto request is still consumed.
- UP/DOWN:
  - Stop request → IDLE.
  - Same-direction request → ignored.
  - Opposite request → DEAD. The pending direction is latched and the counter is cleared.
  - `tope_a_s` in UP (or `tope_b_s` in DOWN) → IDLE, and `at_top` (or `at_bottom`) is set.
- DEAD:
  - Counts `DEAD_CYCLES` cycles, then enters the latched direction.
  - If that direction's limit is asserted at that point → IDLE instead.
  - Stop request → IDLE, pending direction discarded.
  - A new opposite request replaces the latched direction without restarting the count.
- `at_top` and `at_bottom` are cleared when any move starts. They are never both 1.
- `auto_ready` = 1 only when all of these hold:
  - state is IDLE;
  - no manual request (up, down or stop) is active this cycle;
  - `fault` = 0.

## Timing
- All outputs are registered, with 1-cycle latency. A request sampled at edge N changes state and `cmd` at edge N.
- A limit flag sampled high at edge N drives `cmd` to 00 from edge N.
- On reversal, `cmd` is 00 for exactly `DEAD_CYCLES` cycles.
- Reset (asynchronous, any time, including mid-travel or mid-DEAD):
  - state → IDLE;
  - `cmd`=00, `busy`=0, `at_top`=0, `at_bottom`=0, `fault`=0, `auto_ready`=0;
  - counter cleared.
- `auto_ready` may assert in the first cycle after reset release.
- Counter is CNT_W-bit unsigned. It is cleared on entry to UP, DOWN and DEAD and saturates; it never wraps.

## Configuration
- Macro: `MOTOR_SEQ_TIMEOUT_EN`.
- Defined:
  - In UP/DOWN the counter runs. After `TIMEOUT_CYCLES` cycles of continuous travel the block enters FAULT: `cmd`=00, `fault`=1.
  - In FAULT all requests are ignored. `fault_clr` → IDLE at the next edge.
  - `man_stop` does not clear FAULT.
- Undefined:
  - No timeout and no FAULT state; `fault` is tied to 0 and `fault_clr` is ignored.
  - The counter is used only for DEAD.

## Structure
- Shared package `motor_pkg` holds:
  - the state enumeration;
  - `cmd` encodings `CMD_STOP`=00, `CMD_UP`=01, `CMD_DOWN`=10;
  - direction constants.
- The same encodings are shared with `Motor` and house logic.
- One sub-module, `motor_req_arb`: combinational priority arbiter producing the effective request (stop/up/down/none) and `auto_ready`.
- FSM and counter stay in the top module.

## Test plan
Bench uses `DEAD_CYCLES`=4 and `TIMEOUT_CYCLES`=20.
- Reset held low, then released. `man_up` pulsed → `cmd`=01 at the next edge, `busy`=1. `tope_a_s`=1 raised → `cmd`=00, `at_top`=1, `busy`=0.
- Moving UP, `man_down` for 1 cycle → `cmd`=00 for exactly 4 cycles, then 10. `man_stop` during DEAD → IDLE, `cmd` stays 00.
- `auto_valid`=1 with `auto_dir`=0 and `man_up`=1 in the same cycle → `auto_ready`=0, `cmd`=01. After the manual stop, auto is accepted → `cmd`=10.
- In IDLE with `tope_b_s`=1, `auto_valid`=1 and `auto_dir`=0 → handshake completes, `cmd` stays 00, `busy`=0.
- With `MOTOR_SEQ_TIMEOUT_EN`: UP without a limit → `cmd`=01 for 20 cycles, then `fault`=1 and `cmd`=00. `man_up` ignored; `fault_clr` → IDLE with `fault`=0. Without the macro: `cmd` stays 01 past 20 cycles.
- Reset asserted mid-DOWN → `cmd`=00 immediately, without waiting for a clock edge.
